// File: rtl/block_pingpong_ctrl.sv
// ----------------------------------------------------------------------------
// block_pingpong_ctrl
//
// Sequences a ping-pong pair of block buffers. Incoming samples are written
// into the current write bank at an incrementing address. A bank that holds
// BLOCK_SIZE samples is marked full, the writer moves to the other bank, and
// full banks are offered to the consumer oldest-first. When both banks are
// full the controller stalls the upstream stream until the consumer releases
// a bank. Completed blocks are counted modulo 2^CNT_W.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous, active-high reset
//   in_valid     upstream sample valid
//   in_ready     a sample can be accepted this cycle
//   restart      discard the partial block in the write bank, pointer to 0
//   wr_en        buffer write strobe (in_valid & in_ready)
//   wr_bank      bank currently being filled
//   wr_addr      write address within the bank
//   fill_level   samples already written into the current block
//   block_done   one-cycle pulse the cycle after a block's final write
//   blk_valid    a full bank is available to the consumer
//   blk_bank     bank offered to the consumer
//   blk_release  consumer is done with blk_bank (ignored when blk_valid = 0)
//   blk_count    completed blocks since reset, wrapping
// ----------------------------------------------------------------------------
module block_pingpong_ctrl #(
    parameter  int BLOCK_SIZE = 256,
    parameter  int CNT_W      = 16,
    localparam int ADDR_W     = $clog2(BLOCK_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] fill_level,
    output logic              block_done,
    output logic              blk_valid,
    output logic              blk_bank,
    input  logic              blk_release,
    output logic [CNT_W-1:0]  blk_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCK_SIZE - 1);

    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_bank_q;
    logic              rd_bank_q;
    logic [1:0]        full;
    logic              done_q;
    logic [CNT_W-1:0]  cnt_q;

    logic last_write;
    logic release_fire;

    // The bank being filled is never full unless both banks are full, so
    // checking only the write bank is enough to apply backpressure.
    assign in_ready     = !full[wr_bank_q] && !restart;
    assign wr_en        = in_valid && in_ready;
    assign wr_addr      = wr_ptr;
    assign fill_level   = wr_ptr;
    assign wr_bank      = wr_bank_q;
    assign blk_valid    = full[rd_bank_q];
    assign blk_bank     = rd_bank_q;
    assign block_done   = done_q;
    assign blk_count    = cnt_q;

    assign last_write   = wr_en && (wr_ptr == LAST_ADDR);
    assign release_fire = blk_valid && blk_release;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values; blocking here would chain the updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full      <= 2'b00;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // NOTE: done_q defaults low each cycle so it can only pulse for
            // one cycle; the final-write branch below overrides it.
            done_q <= 1'b0;

            if (restart) begin
                // Restart blocks acceptance in the same cycle, so no write
                // can collide with the pointer reset.
                wr_ptr <= '0;
            end else if (last_write) begin
                wr_ptr          <= '0;
                full[wr_bank_q] <= 1'b1;
                wr_bank_q       <= ~wr_bank_q;
                done_q          <= 1'b1;
                cnt_q           <= cnt_q + 1'b1;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            // A release always targets the bank opposite the one being
            // filled, so it never conflicts with the full[] set above.
            if (release_fire) begin
                full[rd_bank_q] <= 1'b0;
                rd_bank_q       <= ~rd_bank_q;
            end
        end
    end

endmodule

// File: tb/tb_block_pingpong_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for block_pingpong_ctrl. Two instances run side by side: one with
// the default geometry (256 / 16) and one small (4 / 2) to exercise counter
// wrap. Each has a driver that pushes expected outputs from a count-based
// reference model into a queue, and a shared monitor that pops and compares
// on the falling edge.
// ----------------------------------------------------------------------------
module tb_block_pingpong_ctrl;

    typedef struct {
        logic [31:0] in_ready;
        logic [31:0] wr_en;
        logic [31:0] wr_bank;
        logic [31:0] wr_addr;
        logic [31:0] blk_valid;
        logic [31:0] blk_bank;
        logic [31:0] block_done;
        logic [31:0] blk_count;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        rst_a = 1'b1, iv_a = 1'b0, rs_a = 1'b0, rl_a = 1'b0;
    logic        a_in_ready, a_wr_en, a_wr_bank, a_block_done, a_blk_valid, a_blk_bank;
    logic [7:0]  a_wr_addr, a_fill_level;
    logic [15:0] a_blk_count;

    // Instance B: BLOCK_SIZE=4, CNT_W=2
    logic        rst_b = 1'b1, iv_b = 1'b0, rs_b = 1'b0, rl_b = 1'b0;
    logic        b_in_ready, b_wr_en, b_wr_bank, b_block_done, b_blk_valid, b_blk_bank;
    logic [1:0]  b_wr_addr, b_fill_level;
    logic [1:0]  b_blk_count;

    block_pingpong_ctrl dut_a (
        .clk(clk), .rst(rst_a), .in_valid(iv_a), .in_ready(a_in_ready),
        .restart(rs_a), .wr_en(a_wr_en), .wr_bank(a_wr_bank),
        .wr_addr(a_wr_addr), .fill_level(a_fill_level),
        .block_done(a_block_done), .blk_valid(a_blk_valid),
        .blk_bank(a_blk_bank), .blk_release(rl_a), .blk_count(a_blk_count)
    );

    block_pingpong_ctrl #(.BLOCK_SIZE(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(iv_b), .in_ready(b_in_ready),
        .restart(rs_b), .wr_en(b_wr_en), .wr_bank(b_wr_bank),
        .wr_addr(b_wr_addr), .fill_level(b_fill_level),
        .block_done(b_block_done), .blk_valid(b_blk_valid),
        .blk_bank(b_blk_bank), .blk_release(rl_b), .blk_count(b_blk_count)
    );

    int total = 0;
    int bad   = 0;

    obs_t exp_q_a[$];
    obs_t exp_q_b[$];

    // Reference model, per instance: counts of samples in the open block,
    // blocks completed and blocks released since reset. Bank indices follow
    // from strict alternation: the write bank is completed%2, the read bank
    // is released%2, and completed-released banks are full.
    int bs[2]        = '{256, 4};
    int cmod[2]      = '{65536, 4};
    int fill[2]      = '{0, 0};
    int done_tot[2]  = '{0, 0};
    int rel_tot[2]   = '{0, 0};
    bit done_pend[2] = '{0, 0};
    bit ap_rst[2]    = '{1, 1};
    bit ap_v[2]      = '{0, 0};
    bit ap_rs[2]     = '{0, 0};
    bit ap_rl[2]     = '{0, 0};

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, got, exp);
        end
    endtask

    function automatic obs_t predict(input int id);
        obs_t p;
        int   full_cnt;
        bit   rdy;
        full_cnt     = done_tot[id] - rel_tot[id];
        rdy          = (full_cnt < 2) && !ap_rs[id];
        p.in_ready   = 32'(rdy);
        p.wr_en      = 32'(ap_v[id] && rdy);
        p.wr_bank    = 32'(done_tot[id] % 2);
        p.wr_addr    = 32'(fill[id]);
        p.blk_valid  = 32'(full_cnt > 0);
        p.blk_bank   = 32'(rel_tot[id] % 2);
        p.block_done = 32'(done_pend[id]);
        p.blk_count  = 32'(done_tot[id] % cmod[id]);
        return p;
    endfunction

    // Advance the model across one rising edge using the inputs applied
    // during the cycle that just ended.
    task automatic model_edge(input int id);
        obs_t o;
        o = predict(id);
        if (ap_rst[id]) begin
            fill[id]      = 0;
            done_tot[id]  = 0;
            rel_tot[id]   = 0;
            done_pend[id] = 1'b0;
        end else begin
            done_pend[id] = 1'b0;
            if (ap_rs[id]) begin
                fill[id] = 0;
            end else if (o.wr_en[0]) begin
                if (fill[id] == bs[id] - 1) begin
                    fill[id]      = 0;
                    done_tot[id]  = done_tot[id] + 1;
                    done_pend[id] = 1'b1;
                end else begin
                    fill[id] = fill[id] + 1;
                end
            end
            if (ap_rl[id] && o.blk_valid[0]) rel_tot[id] = rel_tot[id] + 1;
        end
    endtask

    task automatic cycle(input int id, input bit r, input bit v, input bit rs, input bit rl);
        @(posedge clk);
        model_edge(id);
        #1;
        ap_rst[id] = r; ap_v[id] = v; ap_rs[id] = rs; ap_rl[id] = rl;
        if (id == 0) begin
            rst_a = r; iv_a = v; rs_a = rs; rl_a = rl;
            exp_q_a.push_back(predict(0));
        end else begin
            rst_b = r; iv_b = v; rs_b = rs; rl_b = rl;
            exp_q_b.push_back(predict(1));
        end
    endtask

    task automatic run_random(input int id, input int n, input int rl_div);
        for (int i = 0; i < n; i++) begin
            cycle(id, ($urandom % 3000) == 0, ($urandom % 5) != 0,
                  ($urandom % 300) == 0, ($urandom % rl_div) == 0);
        end
    endtask

    task automatic compare(input string tag, input obs_t g, input obs_t e);
        check({tag, ".in_ready"},   g.in_ready,   e.in_ready);
        check({tag, ".wr_en"},      g.wr_en,      e.wr_en);
        check({tag, ".wr_bank"},    g.wr_bank,    e.wr_bank);
        check({tag, ".wr_addr"},    g.wr_addr,    e.wr_addr);
        check({tag, ".blk_valid"},  g.blk_valid,  e.blk_valid);
        check({tag, ".blk_bank"},   g.blk_bank,   e.blk_bank);
        check({tag, ".block_done"}, g.block_done, e.block_done);
        check({tag, ".blk_count"},  g.blk_count,  e.blk_count);
    endtask

    // Monitor: one expected entry is queued per driven cycle; compare it
    // against the DUT on the falling edge, away from the active edge.
    always @(negedge clk) begin
        obs_t e;
        obs_t g;
        if (exp_q_a.size() > 0) begin
            e = exp_q_a.pop_front();
            g.in_ready = 32'(a_in_ready);   g.wr_en = 32'(a_wr_en);
            g.wr_bank = 32'(a_wr_bank);     g.wr_addr = 32'(a_wr_addr);
            g.blk_valid = 32'(a_blk_valid); g.blk_bank = 32'(a_blk_bank);
            g.block_done = 32'(a_block_done); g.blk_count = 32'(a_blk_count);
            compare("A", g, e);
            check("A.fill_level", 32'(a_fill_level), e.wr_addr);
        end
        if (exp_q_b.size() > 0) begin
            e = exp_q_b.pop_front();
            g.in_ready = 32'(b_in_ready);   g.wr_en = 32'(b_wr_en);
            g.wr_bank = 32'(b_wr_bank);     g.wr_addr = 32'(b_wr_addr);
            g.blk_valid = 32'(b_blk_valid); g.blk_bank = 32'(b_blk_bank);
            g.block_done = 32'(b_block_done); g.blk_count = 32'(b_blk_count);
            compare("B", g, e);
            check("B.fill_level", 32'(b_fill_level), e.wr_addr);
        end
    end

    initial begin
        fork
            begin : drive_a
                cycle(0, 1, 0, 0, 0);
                cycle(0, 1, 0, 0, 0);
                // One full block, then fill the second and keep pushing into
                // backpressure, then release bank 0.
                for (int i = 0; i < 256; i++) cycle(0, 0, 1, 0, 0);
                for (int i = 0; i < 300; i++) cycle(0, 0, 1, 0, 0);
                cycle(0, 0, 1, 0, 1);
                for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
                // Restart after 100 samples, with a sample offered alongside.
                cycle(0, 1, 0, 0, 0);
                for (int i = 0; i < 100; i++) cycle(0, 0, 1, 0, 0);
                cycle(0, 0, 1, 1, 0);
                for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0);
                // Final write of bank 1 coinciding with release of bank 0.
                cycle(0, 1, 0, 0, 0);
                for (int i = 0; i < 511; i++) cycle(0, 0, 1, 0, 0);
                cycle(0, 0, 1, 0, 1);
                for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, 0);
                // Reset with bank 0 full and bank 1 at fill level 37.
                cycle(0, 1, 0, 0, 0);
                for (int i = 0; i < 256 + 37; i++) cycle(0, 0, 1, 0, 0);
                cycle(0, 1, 1, 0, 0);
                for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0);
                run_random(0, 4000, 40);
                cycle(0, 0, 0, 0, 0);
            end
            begin : drive_b
                cycle(1, 1, 0, 0, 0);
                cycle(1, 1, 0, 0, 0);
                // Continuous input with release held high: count wraps 1,2,3,0.
                for (int i = 0; i < 40; i++) cycle(1, 0, 1, 0, 1);
                run_random(1, 1500, 4);
                cycle(1, 0, 0, 0, 0);
            end
        join
        @(negedge clk);
        @(negedge clk);
        check("A.queue_drained", 32'(exp_q_a.size()), 32'd0);
        check("B.queue_drained", 32'(exp_q_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_pingpong_ctrl.md
Name: block_pingpong_ctrl

Overview:
Controller that sequences a ping-pong pair of block buffers in the precision core.
- Accepts a valid/ready sample stream and generates the write enable, bank and address for each sample.
- Marks a bank full after BLOCK_SIZE writes and offers full banks to the downstream consumer in fill order.
- Applies backpressure when both banks are full, and counts completed blocks.

Parameters:
BLOCK_SIZE, 256, samples per block; power of two, >= 2; ADDR_W = $clog2(BLOCK_SIZE)
CNT_W, 16, width of the completed-block counter

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream sample valid
in_ready  output  1  controller can accept a sample this cycle
restart  input  1  discard partial block in the current write bank; pointer returns to 0
wr_en  output  1  buffer write strobe (= in_valid & in_ready)
wr_bank  output  1  bank being filled
wr_addr  output  ADDR_W  write address within bank (current write pointer)
fill_level  output  ADDR_W  samples already written into the current block
block_done  output  1  one-cycle pulse, the cycle after a block's final write
blk_valid  output  1  a full bank is available to the consumer
blk_bank  output  1  bank index offered to the consumer
blk_release  input  1  consumer finished with blk_bank; ignored when blk_valid=0
blk_count  output  CNT_W  completed blocks since reset, wraps modulo 2^CNT_W

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- State registers:
  - wr_ptr[ADDR_W]
  - wr_bank_q
  - rd_bank_q
  - full[1:0]
  - done_q
  - cnt_q[CNT_W]
- Reset values: wr_ptr=0, wr_bank=0, rd_bank=0, full=00, block_done=0, blk_count=0. Resulting outputs: blk_valid=0, in_ready=1, wr_en=0.
- Reset mid-operation discards all buffered and partial blocks. There is no pending output after reset.
- Combinational outputs:
  - in_ready = !full[wr_bank_q] && !restart
  - wr_en = in_valid && in_ready
  - wr_addr = fill_level = wr_ptr
  - wr_bank = wr_bank_q
  - blk_valid = full[rd_bank_q]
  - blk_bank = rd_bank_q
- Accept (wr_en=1), wr_ptr < BLOCK_SIZE-1: wr_ptr += 1.
- Accept with wr_ptr == BLOCK_SIZE-1:
  - wr_ptr <= 0, full[wr_bank_q] <= 1, wr_bank_q <= ~wr_bank_q
  - done_q <= 1 for exactly one cycle; cnt_q += 1, wrapping
- block_done = done_q, so it asserts one cycle after the final write.
- Release: blk_valid && blk_release clears full[rd_bank_q] and sets rd_bank_q <= ~rd_bank_q next cycle.
- Restart:
  - Sets wr_ptr <= 0 and keeps wr_bank unchanged.
  - full[], rd_bank and blk_count are unaffected.
  - A sample presented in the same cycle is not accepted (in_ready=0).
- Both banks full: in_ready=0 and wr_ptr holds at 0. in_ready rises the cycle after a release frees wr_bank.
- Final write and release in the same cycle: always on opposite banks, because the filling bank is never full. Both updates take effect.
- Full-bank ordering: full banks are always offered oldest-first. rd_bank and wr_bank alternate strictly.
- Latency: zero-cycle write path (wr_en is combinational from in_valid); one cycle from final write to blk_valid and block_done.
- No overflow or underflow is possible. blk_release while blk_valid=0 has no effect.

Test Plan:
- Reset, then 256 consecutive in_valid cycles:
  - wr_en on every cycle, wr_bank=0, wr_addr 0..255.
  - Cycle after the last write: block_done=1 for one cycle, blk_valid=1, blk_bank=0, blk_count=1, wr_bank=1, fill_level=0.
- 512 samples with no release:
  - Both banks full, in_ready=0, and further in_valid produces no wr_en.
  - Pulse blk_release: blk_bank becomes 1, and the next cycle in_ready=1, wr_bank=0.
- Restart after 100 samples (fill_level=100):
  - Next accepted sample has wr_addr=0 on the same bank.
  - A sample presented with restart is not written; blk_count is unchanged.
- Final write of bank 1 in the same cycle as blk_release of bank 0:
  - Next cycle full=10, blk_bank=1, blk_valid=1, wr_bank=0, in_ready=1.
- Assert rst while bank 0 is full and bank 1 is at fill_level=37:
  - Next cycle all outputs are at reset values and the first write goes to bank 0, addr 0.
- BLOCK_SIZE=4, CNT_W=2, continuous input with release every block:
  - wr_addr cycles 0,1,2,3; bank alternates each block.
  - blk_count sequence 1,2,3,0, wrapping.
